// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
//
// The RX pin passes through a two-flop synchronizer; everything downstream
// looks only at the synchronized copy rx_s. A low rx_s seen in IDLE is a
// start detection. The start bit is then re-checked half a bit later. Each
// following bit is sampled one full bit period after the previous one:
// 8 data bits LSB first, then the stop bit. The byte is delivered on the
// stop-bit sample together with a sticky ready flag and a framing-error flag.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   RX       serial line, asynchronous to clk, idle-high
//   clr_rdy  consumer acknowledge; clears rdy and frm_err
//   rx_data  last received byte, held until the next stop-bit sample
//   rdy      byte available (sticky)
//   frm_err  stop bit of the last frame was sampled as 0 (sticky)
//
// Handshake: this is a flag interface, not valid/ready streaming. rdy rises
// on the stop-bit sample and stays high until the consumer pulses clr_rdy or
// a new start bit is detected. A byte that lands on the same edge as clr_rdy
// wins, so no byte is lost. rx_data is only written on a stop-bit sample.
//
// BAUD_DIV must be >= 4 and even. The start bit is re-checked BAUD_DIV/2
// clocks after detection.

module uart_rx #(
  parameter int BAUD_DIV = 34
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam int HALF = BAUD_DIV / 2;
  localparam int CW   = $clog2(BAUD_DIV);

  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
  localparam logic [CW-1:0] BAUD_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    STOP_IDX  = 4'd9;

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Synchronizer. Both flops reset high so that reset release never
  // looks like a falling start edge.
  logic rx_m, rx_s;

  // Bit timing
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;

  // The receiver is allowed to start only after rx_s has been high for at
  // least one edge since the last frame. This stops a held-low break from
  // retriggering endlessly.
  logic armed;

  // Decoded events
  logic start_det;
  logic samp;
  logic samp_start;
  logic samp_data;
  logic samp_stop;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    start_det  = 1'b0;
    samp       = 1'b0;
    samp_start = 1'b0;
    samp_data  = 1'b0;
    samp_stop  = 1'b0;

    start_det  = (state == IDLE) && armed && !rx_s;
    samp       = (state == RECEIVE) && (baud_cnt == '0);
    // bit_cnt indexes the bit being sampled:
    //   0     = start bit
    //   1..8  = data bits
    //   9     = stop bit
    samp_start = samp && (bit_cnt == 4'd0);
    samp_stop  = samp && (bit_cnt == STOP_IDX);
    samp_data  = samp && !samp_start && !samp_stop;
  end

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_det) begin
          state_nxt = RECEIVE;
        end
      end
      RECEIVE: begin
        // A line that is high again at mid start bit was a glitch.
        if ((samp_start && rx_s) || samp_stop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Baud and bit counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= 4'd0;
    end else if (start_det) begin
      baud_cnt <= HALF_LOAD;
      bit_cnt  <= 4'd0;
    end else if (state == RECEIVE) begin
      if ((samp_start && rx_s) || samp_stop) begin
        // Leaving the frame: park the counters so bit_cnt never passes 9.
        baud_cnt <= '0;
        bit_cnt  <= 4'd0;
      end else if (samp) begin
        baud_cnt <= BAUD_LOAD;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        baud_cnt <= baud_cnt - CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data shift register. The register shifts right, so after eight shifts
  // the first data bit received sits in bit 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= 8'h00;
    end else if (samp_data) begin
      shreg <= {rx_s, shreg[7:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Re-arm tracking. At the stop sample, a high stop bit counts as the
  // required high edge, so a start that follows directly is accepted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b1;
    end else if (samp_stop) begin
      armed <= rx_s;
    end else if ((state == IDLE) && rx_s) begin
      armed <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output byte and status flags. Delivery on the stop sample has priority
  // over clearing, so a byte landing on the same edge as clr_rdy is kept.
  // The byte is delivered even when the stop bit is bad.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
    end else if (samp_stop) begin
      rx_data <= shreg;
      rdy     <= 1'b1;
      frm_err <= ~rx_s;
    end else if (start_det || clr_rdy) begin
      rdy     <= 1'b0;
      frm_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx.
//
// The bench has four parts:
//   - a clock and reset block;
//   - a bit-level serial driver that acts as the UART transmitter;
//   - a scoreboard queue of expected {frm_err, byte} results;
//   - a final report.
//
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge, away from the active rising edge.
//
// Timing reference: within one frame, iteration i of the driver loop runs
// at the falling edge just after rising edge E_i. The start bit is driven
// at i = 0, so E_1 is the first edge that sees it. From the timing rules:
//   - the synchronizer adds two edges, so detection happens at E_3;
//   - the stop sample lands at E_(3 + 17 + 9*34) = E_326.
// So rdy must be low at i = 325 and high at i = 326.

module tb_uart_rx;

  localparam int BAUD_DIV = 34;
  localparam int STOP_I   = 326;   // first iteration where the byte is visible

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];   // {frm_err, data}, one entry per delivered frame

  uart_rx #(.BAUD_DIV(BAUD_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (rx),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  // Receiver is busy while the FSM is out of IDLE.
  assign busy = dut.state;

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Comparison helper
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold the line high for n clocks.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Serial driver plus reference model.
  //
  // The wire image is {stop, data, start}, sent LSB first with BAUD_DIV
  // clocks per bit. The stop level is held for stop_len clocks.
  //
  // The expected result is the data byte as sent, with frm_err set when the
  // stop level is 0.
  //
  // rst_at >= 0 pulses reset at that iteration. In that case the frame is
  // aborted and no result is expected.
  // ---------------------------------------------------------------------------
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len,
                            input bit clr_at_stop, input int rst_at);
    logic [9:0] bits;
    logic [8:0] exp;
    int         total;
    int         idx;
    bits  = {stop, d, 1'b0};
    total = 9 * BAUD_DIV + stop_len;
    if (rst_at < 0) exp_q.push_back({~stop, d});
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (i == 4) chk("start_clears_rdy", rdy, 0);
      if (rst_at >= 0 && i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_rdy", rdy, 0);
        chk("async_rst_data", rx_data, 0);
        chk("async_rst_frm", frm_err, 0);
        chk("async_rst_state", busy, 0);
      end
      if (rst_at >= 0 && i == rst_at + 3) rst_n = 1'b1;
      if (rst_at < 0 && i == STOP_I - 1) begin
        chk("rdy_not_early", rdy, 0);
        if (clr_at_stop) clr_rdy = 1'b1;
      end
      if (rst_at < 0 && i == STOP_I) begin
        clr_rdy = 1'b0;
        exp = exp_q.pop_front();
        chk("rdy_at_stop", rdy, 1);
        chk("rx_data", rx_data, exp[7:0]);
        chk("frm_err", frm_err, exp[8]);
      end
      idx = i / BAUD_DIV;
      rx  = (idx > 9) ? stop : bits[idx];
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] b;
    logic       s;
    logic [7:0] loop_bytes[3];

    loop_bytes[0] = 8'h00;
    loop_bytes[1] = 8'hFF;
    loop_bytes[2] = 8'h5A;

    // Reset
    rst_n   = 1'b0;
    rx      = 1'b1;
    clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", rx_data, 0);
    chk("reset_rdy", rdy, 0);
    chk("reset_frm", frm_err, 0);
    chk("reset_state", busy, 0);
    rst_n = 1'b1;
    idle(5);
    chk("idle_no_start", busy, 0);

    // Single frame with exact rdy timing checks inside the driver
    send_frame(8'hA5, 1'b1, BAUD_DIV, 1'b0, -1);
    idle(10);

    // Back-to-back frames with no idle gap
    send_frame(8'h3C, 1'b1, BAUD_DIV, 1'b0, -1);
    send_frame(8'hC3, 1'b1, BAUD_DIV, 1'b0, -1);
    idle(10);

    // Start glitch: 10 clocks low. The frame must be abandoned at the
    // start-bit re-check on E_20.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 10) chk("glitch_busy", busy, 1);
      if (i == 19) chk("glitch_still_busy", busy, 1);
      if (i == 21) chk("glitch_back_idle", busy, 0);
      if (i == 29) chk("glitch_no_rdy", rdy, 0);
      rx = (i < 10) ? 1'b0 : 1'b1;
    end
    send_frame(8'h55, 1'b1, BAUD_DIV, 1'b0, -1);
    idle(10);

    // Framing error, then the line is held low for 3 more bit times
    send_frame(8'h81, 1'b0, 4 * BAUD_DIV, 1'b0, -1);
    chk("break_rdy_held", rdy, 1);
    chk("break_frm_held", frm_err, 1);
    chk("break_no_restart", busy, 0);
    idle(20);
    send_frame(8'h7E, 1'b1, BAUD_DIV, 1'b0, -1);
    idle(10);

    // Pure break from idle: the line is low for the whole frame and beyond
    send_frame(8'h00, 1'b0, 3 * BAUD_DIV, 1'b0, -1);
    chk("break_no_restart2", busy, 0);
    idle(20);

    // clr_rdy after a frame with a framing error clears both flags
    send_frame(8'h96, 1'b0, BAUD_DIV, 1'b0, -1);
    idle(5);
    @(negedge clk);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    chk("clr_rdy", rdy, 0);
    chk("clr_frm", frm_err, 0);
    chk("clr_keeps_data", rx_data, 8'h96);
    idle(10);

    // clr_rdy on the stop-sample edge: delivery wins
    send_frame(8'h69, 1'b1, BAUD_DIV, 1'b1, -1);
    send_frame(8'h18, 1'b0, BAUD_DIV, 1'b1, -1);
    idle(10);

    // Loopback bytes, then random bytes, stop lengths and idle gaps
    foreach (loop_bytes[k]) begin
      send_frame(loop_bytes[k], 1'b1, BAUD_DIV, 1'b0, -1);
    end
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      send_frame(b, s, BAUD_DIV + int'($urandom_range(0, 40)), 1'b0, -1);
      // After a bad stop bit the line must go high before the next start.
      idle(s ? int'($urandom_range(0, 20)) : int'($urandom_range(3, 20)));
    end
    idle(10);

    // Reset asserted during data bit 4 of 0xFF: no byte may appear
    send_frame(8'hFF, 1'b1, BAUD_DIV, 1'b0, 5 * BAUD_DIV + 10);
    idle(20);
    chk("rst_no_rdy", rdy, 0);
    chk("rst_no_data", rx_data, 0);

    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
